btle_phy_sequencer: RTL and testbench

//  Link-layer-facing sequencer for the BTLE PHY (btle_tx + btle_rx). Accepts one command
//  (TX, RX or TX-then-RX), loads channel/CRC-init into the PHY and fires tx_start.

---
 rtl/btle_phy_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_btle_phy_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btle_phy_sequencer.sv
// btle_phy_sequencer
//   Link-layer-facing sequencer for the BTLE PHY. Accepts one command (TX, RX or
//   TX-then-RX), loads channel/CRC-init into the PHY, fires tx_start, inserts the
//   T_IFS turnaround, opens a timed RX window and reports one status per command.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid / cmd_ready            command handshake
//   cmd_tx_en, cmd_rx_en             requested phases (both = TX then RX)
//   cmd_channel, cmd_crc_init        PHY configuration for the command
//   cmd_rx_timeout_us                RX window in us, 0 = no timeout
//   abort                            terminate current command (status 3)
//   tx_channel_number(_load)         PHY TX channel + 1-cycle load strobe
//   tx_crc_state_init_bit(_load)     PHY TX CRC init + 1-cycle load strobe
//   tx_start, tx_phy_bit_valid_last  PHY TX start pulse / end-of-packet
//   rx_channel_number, rx_crc_state_init_bit  PHY RX configuration
//   rx_enable                        gates rx_iq_valid into the PHY
//   rx_hit_flag, rx_decode_end, rx_crc_ok     PHY RX status
//   busy, done, status               progress, completion pulse, result code
//   retx_count                       retries used (BTLE_SEQ_AUTO_RETX_EN only)
//
// Optional feature: define BTLE_SEQ_AUTO_RETX_EN to retry TX+RX commands that end
// in CRC_FAIL or TIMEOUT, up to MAX_RETX times.

module btle_phy_sequencer #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int CLK_PER_US               = 16,
    parameter int T_IFS_US                 = 150,
    parameter int TIMER_BIT_WIDTH          = 16
`ifdef BTLE_SEQ_AUTO_RETX_EN
    ,
    parameter int MAX_RETX                 = 3
`endif
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_tx_en,
    input  logic                                cmd_rx_en,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cmd_channel,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      cmd_crc_init,
    input  logic [TIMER_BIT_WIDTH-1:0]          cmd_rx_timeout_us,
    input  logic                                abort,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number,
    output logic                                tx_channel_number_load,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      tx_crc_state_init_bit,
    output logic                                tx_crc_state_init_bit_load,
    output logic                                tx_start,
    input  logic                                tx_phy_bit_valid_last,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rx_channel_number,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      rx_crc_state_init_bit,
    output logic                                rx_enable,
    input  logic                                rx_hit_flag,
    input  logic                                rx_decode_end,
    input  logic                                rx_crc_ok,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          status
`ifdef BTLE_SEQ_AUTO_RETX_EN
    ,
    output logic [1:0]                          retx_count
`endif
);

    localparam int IFS_CYCLES = T_IFS_US * CLK_PER_US;
    localparam int IFS_W      = $clog2(IFS_CYCLES + 1);
    localparam int PRE_W      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [IFS_W-1:0] IFS_LAST = IFS_W'(IFS_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_CRC_FAIL = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] ST_ABORTED  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TX_START, S_TX_WAIT, S_IFS, S_RX_WAIT, S_RX_DECODE, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [1:0] status_q, status_d;

    logic                                tx_en_q, rx_en_q;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_q;
    logic [CRC_STATE_BIT_WIDTH-1:0]      crc_q;
    logic [TIMER_BIT_WIDTH-1:0]          timeout_q;

    logic [IFS_W-1:0]           ifs_cnt;
    logic [PRE_W-1:0]           presc;
    logic [TIMER_BIT_WIDTH-1:0] us_cnt, us_next;
    logic                       us_tick, timeout_hit;
    logic                       accept;
    logic                       finish;
    logic [1:0]                 finish_status;

`ifdef BTLE_SEQ_AUTO_RETX_EN
    logic [1:0] retx_q, retx_d;
    assign retx_count = retx_q;
`endif

    assign accept = (state_q == S_IDLE) && cmd_valid;

    // Timeout is judged on the value the us counter is about to take, so the
    // command ends exactly timeout*CLK_PER_US cycles after rx_enable rises.
    assign us_tick     = (presc == PRE_LAST);
    assign us_next     = (us_cnt == '1) ? us_cnt : us_cnt + 1'b1;
    assign timeout_hit = us_tick && (timeout_q != '0) && (us_next == timeout_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            status_q  <= ST_OK;
            tx_en_q   <= 1'b0;
            rx_en_q   <= 1'b0;
            channel_q <= '0;
            crc_q     <= '0;
            timeout_q <= '0;
            ifs_cnt   <= '0;
            presc     <= '0;
            us_cnt    <= '0;
`ifdef BTLE_SEQ_AUTO_RETX_EN
            retx_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
`ifdef BTLE_SEQ_AUTO_RETX_EN
            retx_q   <= accept ? 2'd0 : retx_d;
`endif
            if (accept) begin
                tx_en_q   <= cmd_tx_en;
                rx_en_q   <= cmd_rx_en;
                channel_q <= cmd_channel;
                crc_q     <= cmd_crc_init;
                timeout_q <= cmd_rx_timeout_us;
            end

            ifs_cnt <= (state_q == S_IFS) ? ifs_cnt + 1'b1 : '0;

            if (state_q == S_RX_WAIT) begin
                presc <= us_tick ? '0 : presc + 1'b1;
                if (us_tick) us_cnt <= us_next;
            end else if (state_q != S_RX_DECODE) begin
                presc  <= '0;
                us_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        finish        = 1'b0;
        finish_status = ST_OK;
`ifdef BTLE_SEQ_AUTO_RETX_EN
        retx_d        = retx_q;
`endif
        case (state_q)
            S_IDLE:     if (cmd_valid) state_d = S_LOAD;
            S_LOAD: begin
                if (tx_en_q)      state_d = S_TX_START;
                else if (rx_en_q) state_d = S_RX_WAIT;
                else              finish  = 1'b1;
            end
            S_TX_START: state_d = S_TX_WAIT;
            S_TX_WAIT: begin
                if (tx_phy_bit_valid_last) begin
                    if (rx_en_q) state_d = S_IFS;
                    else         finish  = 1'b1;
                end
            end
            S_IFS:      if (ifs_cnt == IFS_LAST) state_d = S_RX_WAIT;
            S_RX_WAIT: begin
                // A hit in the timeout cycle still wins.
                if (rx_hit_flag) begin
                    state_d = S_RX_DECODE;
                end else if (timeout_hit) begin
                    finish        = 1'b1;
                    finish_status = ST_TIMEOUT;
                end
            end
            S_RX_DECODE: begin
                if (rx_decode_end) begin
                    finish        = 1'b1;
                    finish_status = rx_crc_ok ? ST_OK : ST_CRC_FAIL;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (finish) begin
            state_d  = S_DONE;
            status_d = finish_status;
`ifdef BTLE_SEQ_AUTO_RETX_EN
            // Failed TX+RX outcomes restart at TX_START with the latched config.
            if (finish_status != ST_OK && tx_en_q && rx_en_q && int'(retx_q) < MAX_RETX) begin
                state_d  = S_TX_START;
                status_d = status_q;
                retx_d   = retx_q + 2'd1;
            end
`endif
        end

        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d  = S_DONE;
            status_d = ST_ABORTED;
        end
    end

    assign cmd_ready                  = (state_q == S_IDLE);
    assign busy                       = (state_q != S_IDLE);
    assign done                       = (state_q == S_DONE);
    assign status                     = status_q;
    assign tx_start                   = (state_q == S_TX_START);
    assign tx_channel_number_load     = (state_q == S_LOAD);
    assign tx_crc_state_init_bit_load = (state_q == S_LOAD);
    assign rx_enable                  = (state_q == S_RX_WAIT) || (state_q == S_RX_DECODE);
    assign tx_channel_number          = channel_q;
    assign tx_crc_state_init_bit      = crc_q;
    assign rx_channel_number          = channel_q;
    assign rx_crc_state_init_bit      = crc_q;

endmodule

// File: tb/tb_btle_phy_sequencer.sv
module tb_btle_phy_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_tx_en, cmd_rx_en, abort;
    logic [5:0]  cmd_channel;
    logic [23:0] cmd_crc_init;
    logic [15:0] cmd_rx_timeout_us;
    logic [5:0]  tx_channel_number, rx_channel_number;
    logic [23:0] tx_crc_state_init_bit, rx_crc_state_init_bit;
    logic        tx_channel_number_load, tx_crc_state_init_bit_load, tx_start;
    logic        tx_phy_bit_valid_last, rx_enable, rx_hit_flag, rx_decode_end, rx_crc_ok;
    logic        busy, done;
    logic [1:0]  status;
`ifdef BTLE_SEQ_AUTO_RETX_EN
    logic [1:0]  retx_count;
`endif

    int checks = 0;
    int errors = 0;
    int n;
    int cnt;
    logic rose;

    always #5 clk = ~clk;

    btle_phy_sequencer #(
        .CHANNEL_NUMBER_BIT_WIDTH(6),
        .CRC_STATE_BIT_WIDTH(24),
        .CLK_PER_US(16),
        .T_IFS_US(150),
        .TIMER_BIT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_tx_en(cmd_tx_en), .cmd_rx_en(cmd_rx_en),
        .cmd_channel(cmd_channel), .cmd_crc_init(cmd_crc_init),
        .cmd_rx_timeout_us(cmd_rx_timeout_us), .abort(abort),
        .tx_channel_number(tx_channel_number), .tx_channel_number_load(tx_channel_number_load),
        .tx_crc_state_init_bit(tx_crc_state_init_bit),
        .tx_crc_state_init_bit_load(tx_crc_state_init_bit_load),
        .tx_start(tx_start), .tx_phy_bit_valid_last(tx_phy_bit_valid_last),
        .rx_channel_number(rx_channel_number), .rx_crc_state_init_bit(rx_crc_state_init_bit),
        .rx_enable(rx_enable), .rx_hit_flag(rx_hit_flag),
        .rx_decode_end(rx_decode_end), .rx_crc_ok(rx_crc_ok),
        .busy(busy), .done(done), .status(status)
`ifdef BTLE_SEQ_AUTO_RETX_EN
        , .retx_count(retx_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one cycle; returns just after the accept edge (LOAD state).
    task automatic send_cmd(input logic tx, input logic rx, input logic [5:0] ch,
                            input logic [23:0] crc, input logic [15:0] to);
        cmd_tx_en = tx; cmd_rx_en = rx; cmd_channel = ch;
        cmd_crc_init = crc; cmd_rx_timeout_us = to; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_tx_en = 1'b0; cmd_rx_en = 1'b0;
        cmd_channel = '0; cmd_crc_init = '0; cmd_rx_timeout_us = '0; abort = 1'b0;
        tx_phy_bit_valid_last = 1'b0; rx_hit_flag = 1'b0; rx_decode_end = 1'b0; rx_crc_ok = 1'b0;

        // Reset values
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_rx_enable", rx_enable, 0);
        chk("rst_tx_channel", tx_channel_number, 0);
        chk("rst_tx_crc", tx_crc_state_init_bit, 0);
        #10 rst_n = 1'b1;
        step();

        // TX only, ch=37, crc=555555
        send_cmd(1'b1, 1'b0, 6'd37, 24'h555555, 16'd0);
        chk("t1_chan_load", tx_channel_number_load, 1);
        chk("t1_crc_load", tx_crc_state_init_bit_load, 1);
        chk("t1_chan", tx_channel_number, 37);
        chk("t1_crc", tx_crc_state_init_bit, 24'h555555);
        chk("t1_no_start_yet", tx_start, 0);
        chk("t1_ready_low", cmd_ready, 0);
        chk("t1_busy", busy, 1);
        step();
        chk("t1_tx_start", tx_start, 1);
        chk("t1_load_gone", tx_channel_number_load, 0);
        step();
        chk("t1_start_pulse", tx_start, 0);
        // cmd_valid while busy must be ignored
        cmd_valid = 1'b1; cmd_channel = 6'd5;
        repeat (3) step();
        cmd_valid = 1'b0;
        chk("t1_busy_ignored_chan", tx_channel_number, 37);
        chk("t1_busy_no_load", tx_channel_number_load, 0);
        tx_phy_bit_valid_last = 1'b1;
        step();
        tx_phy_bit_valid_last = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_status", status, 0);
        chk("t1_done_busy", busy, 1);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ready", cmd_ready, 1);

        // Abort wins over same-cycle TX end
        send_cmd(1'b1, 1'b0, 6'd1, 24'h000111, 16'd0);
        step(); step();
        abort = 1'b1; tx_phy_bit_valid_last = 1'b1;
        step();
        abort = 1'b0; tx_phy_bit_valid_last = 1'b0;
        chk("t6_done", done, 1);
        chk("t6_status_abort", status, 3);
        step();

        // TX+RX, timeout 100us, hit then decode ok
        send_cmd(1'b1, 1'b1, 6'd12, 24'h123456, 16'd100);
        step(); step();
        tx_phy_bit_valid_last = 1'b1;
        step();
        tx_phy_bit_valid_last = 1'b0;
        n = 0;
        while (!rx_enable && n < 3000) begin step(); n++; end
        chk("t2_ifs_cycles", n, 2400);
        chk("t2_rx_chan", rx_channel_number, 12);
        chk("t2_rx_crc", rx_crc_state_init_bit, 24'h123456);
        repeat (5) step();
        rx_hit_flag = 1'b1;
        step();
        rx_hit_flag = 1'b0;
        chk("t2_decode_rx_en", rx_enable, 1);
        chk("t2_decode_not_done", done, 0);
        repeat (3) step();
        rx_decode_end = 1'b1; rx_crc_ok = 1'b1;
        step();
        rx_decode_end = 1'b0; rx_crc_ok = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_status_ok", status, 0);
        chk("t2_done_rx_en", rx_enable, 0);
        step();

        // RX only, timeout 10us, no hit
        send_cmd(1'b0, 1'b1, 6'd3, 24'hABCDEF, 16'd10);
        chk("t3_load_rx_en", rx_enable, 0);
        step();
        chk("t3_rx_en", rx_enable, 1);
        chk("t3_no_tx_start", tx_start, 0);
        n = 0;
        while (!done && n < 400) begin step(); n++; end
        chk("t3_timeout_cycles", n, 160);
        chk("t3_status_timeout", status, 2);
        chk("t3_rx_en_off", rx_enable, 0);
        step();

        // RX only, timeout 1us, hit in the timeout cycle
        send_cmd(1'b0, 1'b1, 6'd7, 24'h000001, 16'd1);
        step();
        repeat (15) step();
        rx_hit_flag = 1'b1;
        step();
        rx_hit_flag = 1'b0;
        chk("t4_hit_wins_done", done, 0);
        chk("t4_hit_wins_rx_en", rx_enable, 1);
        repeat (40) step();
        chk("t4_decode_no_timeout", done, 0);
        rx_decode_end = 1'b1; rx_crc_ok = 1'b0;
        step();
        rx_decode_end = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_status_crc_fail", status, 1);
        step();

        // TX+RX, abort during IFS
        send_cmd(1'b1, 1'b1, 6'd20, 24'h0F0F0F, 16'd50);
        step(); step();
        tx_phy_bit_valid_last = 1'b1;
        step();
        tx_phy_bit_valid_last = 1'b0;
        repeat (100) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_status_abort", status, 3);
        chk("t5_rx_en", rx_enable, 0);
        rose = 1'b0;
        repeat (2600) begin step(); if (rx_enable) rose = 1'b1; end
        chk("t5_rx_never_rose", rose, 0);
        chk("t5_idle", busy, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_idle_abort_ready", cmd_ready, 1);
        chk("t5_idle_abort_done", done, 0);
        chk("t5_status_held", status, 3);

`ifdef BTLE_SEQ_AUTO_RETX_EN
        // Four timeouts: four tx_start pulses, one done with status 2
        tx_phy_bit_valid_last = 1'b1;
        send_cmd(1'b1, 1'b1, 6'd9, 24'h00AA00, 16'd1);
        n = 0; cnt = 0;
        while (!done && n < 20000) begin if (tx_start) cnt++; step(); n++; end
        tx_phy_bit_valid_last = 1'b0;
        chk("rt_tx_starts", cnt, 4);
        chk("rt_done", done, 1);
        chk("rt_status", status, 2);
        chk("rt_retx_count", retx_count, 3);
        cnt = 0;
        repeat (50) begin step(); if (done) cnt++; end
        chk("rt_single_done", cnt, 0);
`endif

        // Reset mid-command
        send_cmd(1'b1, 1'b1, 6'd9, 24'h777777, 16'd5);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_ready", cmd_ready, 1);
        chk("t7_rst_chan", tx_channel_number, 0);
        chk("t7_rst_rx_crc", rx_crc_state_init_bit, 0);
        chk("t7_rst_status", status, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t7_post_rst_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
